// File: rtl/video_clk_pkg.sv
// rtl/video_clk_pkg.sv - shared types, rate constants and helpers for the clock-enable NCO
package video_clk_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } clk_state_t;

    localparam int ACC_W_DEFAULT = 32;

    localparam logic [31:0] INC_25M_AT_50M = 32'h8000_0000;
    localparam logic [31:0] INC_33M_AT_50M = 32'hA8F5_C28F;

    // Select/counter width that never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_nco_channel.sv
// rtl/video_nco_channel.sv - one phase accumulator producing a carry-out clock-enable strobe
module video_nco_channel
    import video_clk_pkg::*;
#(
    parameter int               ACC_W       = ACC_W_DEFAULT,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 32'h8000_0000
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [ACC_W-1:0] load_inc,
    output logic             clken
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            inc   <= DEFAULT_INC;
            clken <= 1'b0;
        end else begin
            if (load) begin
                inc <= load_inc;
            end
            // Clearing zeroes the phase so every channel cleared together restarts aligned.
            if (clear) begin
                acc   <= '0;
                clken <= 1'b0;
            end else begin
                {clken, acc} <= {1'b0, acc} + {1'b0, inc};
            end
        end
    end

endmodule

// File: rtl/video_clken_nco.sv
// rtl/video_clken_nco.sv - multi-channel pixel clock-enable NCO with PLL-style lock indication
module video_clken_nco
    import video_clk_pkg::*;
#(
    parameter int               NUM_CH      = 3,
    parameter int               ACC_W       = ACC_W_DEFAULT,
    parameter int               LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 32'h8000_0000
) (
    input  logic                         refclk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_all,
    input  logic [sel_width(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]             cfg_inc,
    output logic                         cfg_err,
    output logic [NUM_CH-1:0]            clken,
    output logic                         locked
);

    localparam int                 CH_W     = sel_width(NUM_CH);
    localparam int                 CNT_W    = sel_width(LOCK_CYCLES);
    localparam logic [CH_W:0]      NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

    clk_state_t        state;
    logic [CNT_W-1:0]  settle_cnt;
    logic [NUM_CH-1:0] tgt;
    logic [NUM_CH-1:0] apply_mask;
    logic [NUM_CH-1:0] load_mask;
    logic              accept;
    logic              ch_ok;

    assign accept    = cfg_valid && cfg_ready;
    assign ch_ok     = cfg_all || ({1'b0, cfg_ch} < NUM_CH_V);
    assign load_mask = (accept && ch_ok) ? tgt : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign tgt[g] = cfg_all || (cfg_ch == CH_W'(g));

        // Targeted channels stay cleared through APPLY; the first carry comes after it.
        video_nco_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_nco (
            .refclk   (refclk),
            .rst      (rst),
            .load     (load_mask[g]),
            .clear    (load_mask[g] || apply_mask[g]),
            .load_inc (cfg_inc),
            .clken    (clken[g])
        );
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= CNT_LOAD;
            cfg_ready  <= 1'b0;
            locked     <= 1'b0;
            cfg_err    <= 1'b0;
            apply_mask <= '0;
        end else begin
            cfg_err <= accept && !ch_ok;
            case (state)
                SETTLE, LOCKED: begin
                    cfg_ready <= 1'b1;
                    if (accept && ch_ok) begin
                        state      <= APPLY;
                        cfg_ready  <= 1'b0;
                        locked     <= 1'b0;
                        apply_mask <= tgt;
                    end else if (state == SETTLE) begin
                        if (settle_cnt == '0) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end
                    end
                end
                APPLY: begin
                    state      <= SETTLE;
                    settle_cnt <= CNT_LOAD;
                    cfg_ready  <= 1'b1;
                    apply_mask <= '0;
                end
                default: begin
                    state      <= SETTLE;
                    settle_cnt <= CNT_LOAD;
                    cfg_ready  <= 1'b0;
                    locked     <= 1'b0;
                    apply_mask <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/video_clken_nco.md
Name: video_clken_nco

Overview:
- Parametrised, runtime-reconfigurable successor to the fixed-frequency video PLL wrapper.
- Generates NUM_CH independent pixel-rate clock-enable strobes from `refclk` using per-channel phase accumulators (NCOs). Any rate up to `refclk` can be produced without regenerating IP, e.g. 25 MHz and 33 MHz strobes from a 50 MHz reference.
- Sits beside the VGA timing generators; each channel's `clken` qualifies logic clocked by `refclk`.
- A `locked` flag reproduces PLL-style lock semantics across reset and reconfiguration.

Parameters:
- NUM_CH, 3, number of enable channels (1..16).
- ACC_W, 32, accumulator and increment width in bits.
- LOCK_CYCLES, 16, settle cycles before `locked` asserts (>=1).
- DEFAULT_INC, 32'h8000_0000, reset increment for every channel (refclk/2).

Ports:
- refclk  in  1  sole clock; all logic rises on it.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer occurs when valid && ready at a rising edge.
- cfg_all  in  1  1 = broadcast to all channels, ignoring cfg_ch.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment; f_out = f_ref*inc/2^ACC_W.
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH with cfg_all=0.
- clken  out  NUM_CH  per-channel enable strobe, one refclk cycle wide.
- locked  out  1  high when configuration is stable.

Behaviour:
- Reset (async assert, release sync to refclk):
  - acc[i]=0, inc[i]=DEFAULT_INC, clken=0, cfg_err=0, locked=0, cfg_ready=0.
  - state=SETTLE, settle counter = LOCK_CYCLES-1.
- NCO, every edge for each channel not being cleared:
  - {carry, acc[i]} <= acc[i] + inc[i], computed ACC_W+1 wide with natural wrap.
  - clken[i] <= carry.
  - With inc=2^31: clken is high on edges 2, 4, 6... after reset release.
- inc=0: channel frozen; clken stays 0.
- Largest inc (all ones): clken high on every edge except one in each 2^ACC_W.
- States are SETTLE, LOCKED and APPLY.
  - SETTLE: cfg_ready=1, locked=0. Counter decrements each edge; at 0 the state goes to LOCKED, so locked rises on the LOCK_CYCLES-th edge after entry.
  - LOCKED: cfg_ready=1, locked=1.
  - APPLY: exactly 1 cycle, cfg_ready=0, locked=0; then SETTLE with counter reloaded to LOCK_CYCLES-1.
- Valid config accept (in SETTLE or LOCKED):
  - Targeted channel(s) get inc <= cfg_inc; acc and clken clear on the same edge, which phase-aligns channels on broadcast.
  - State goes to APPLY.
  - Untargeted channels keep running without a glitch.
- Invalid channel accept: no register or state change; cfg_err pulses high for the following cycle.
- Accept during SETTLE restarts the settle count. locked never glitches high mid-settle.
- APPLY cycle: targeted channels hold acc=0 and clken=0; the first carry is evaluated on the next edge.
- Reset asserted mid-APPLY or mid-SETTLE: immediate return to reset values, including DEFAULT_INC. Any config in progress is lost.
- cfg_valid held high: a second transfer is accepted in the first SETTLE cycle after APPLY.

Decomposition:
- Package `video_clk_pkg`:
  - state enum `clk_state_t` {SETTLE, LOCKED, APPLY};
  - ACC_W default;
  - rate constants INC_25M_AT_50M=32'h8000_0000 and INC_33M_AT_50M=32'hA8F5_C28F;
  - channel-width function.
- Sub-module `video_nco_channel`: one accumulator, its increment register, clear and load inputs, clken output. Instantiate it NUM_CH times with a generate loop.
- Top level holds the FSM, settle counter and config decode.

Test Plan:
1. Reset then 40 cycles -> locked rises on edge 16; all 3 clken toggle on every other cycle (20 pulses each over 40 cycles).
2. Set ch2 inc=0xA8F5_C28F, then count over 10000 cycles after lock -> 6600 +/-1 pulses on clken[2]; ch0/ch1 unaffected at 5000 each; locked low for 17 cycles after the accept.
3. Broadcast inc=0x4000_0000 -> all channels clear together, then pulse simultaneously every 4th cycle.
4. cfg_ch=3 with NUM_CH=3, cfg_all=0 -> cfg_err pulses once; locked stays 1; rates unchanged.
5. Second config issued 5 cycles into SETTLE -> settle restarts, locked rises 17 cycles after the second accept, never earlier.
6. Assert rst during APPLY -> clken=0 and locked=0 immediately; after release, DEFAULT_INC behaviour matches scenario 1.
